sram_ctl_s3board: RTL and testbench

//  Initiator for the two IS61LV25616 256Kx16 async SRAMs on the s3board.

---
 rtl/sram_ctl_s3board.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sram_ctl_s3board.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctl_s3board.sv
// sram_ctl_s3board
// Initiator for the two IS61LV25616 256Kx16 asynchronous SRAMs on the s3board.
// A single-word request (req/ack handshake) becomes a timed sequence of
// ce_n/oe_n/we_n/ub_n/lb_n strobes on the shared address bus.
//
// Ports
//   clk, reset           clock and synchronous active-high reset
//   req, we, bank        request strobe, 1=write/0=read, 0=ram1/1=ram2
//   addr, wdata, be      word address, write data, byte enables {ub,lb}
//   rdata, ack, busy     read data, one-cycle completion pulse, busy flag
//   ram_a, ram_oe_n,     shared SRAM address and output/write enables
//   ram_we_n
//   ram1_*/ram2_*        per-chip data bus and chip/byte selects
//
// Every output is a register.  Each output's next value is decoded from the
// next state, so each strobe changes exactly on the edge that enters a state.
module sram_ctl_s3board #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        bank,
  input  logic [17:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [17:0] ram_a,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  inout  wire  [15:0] ram1_io,
  output logic        ram1_ce_n,
  output logic        ram1_ub_n,
  output logic        ram1_lb_n,
  inout  wire  [15:0] ram2_io,
  output logic        ram2_ce_n,
  output logic        ram2_ub_n,
  output logic        ram2_lb_n
);

  // Strobe counts below 1 are treated as 1.
  localparam int RD_N = (READ_CYCLES  < 1) ? 1 : READ_CYCLES;
  localparam int WR_N = (WRITE_CYCLES < 1) ? 1 : WRITE_CYCLES;
  localparam logic [7:0] RD_LAST = 8'(RD_N - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_WSETUP  = 3'd2,
    S_WSTROBE = 3'd3,
    S_WHOLD   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Operation latched at accept.
  logic        we_q, we_d;
  logic        bank_q, bank_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;

  // Registered outputs.
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [17:0] ram_a_q, ram_a_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ce1_n_q, ce1_n_d;
  logic        ub1_n_q, ub1_n_d;
  logic        lb1_n_q, lb1_n_d;
  logic        ce2_n_q, ce2_n_d;
  logic        ub2_n_q, ub2_n_d;
  logic        lb2_n_q, lb2_n_d;
  logic        drv1_q, drv1_d;
  logic        drv2_q, drv2_d;

  // Next state, operation latch and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
      S_IDLE, S_DONE: begin
        if (req) begin
          we_d    = we;
          bank_d  = bank;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = 8'd0;
          state_d = we ? S_WSETUP : S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          // Capture on the edge that ends the last oe_n-low cycle.
          rdata_d = bank_q ? ram2_io : ram1_io;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WSETUP: begin
        cnt_d   = 8'd0;
        state_d = S_WSTROBE;
      end
      S_WSTROBE: begin
        if (cnt_q == WR_LAST) begin
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WHOLD: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the state being entered.
  always_comb begin
    ack_d   = 1'b0;
    busy_d  = 1'b0;
    ram_a_d = ram_a_q;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ce1_n_d = 1'b1;
    ub1_n_d = 1'b1;
    lb1_n_d = 1'b1;
    ce2_n_d = 1'b1;
    ub2_n_d = 1'b1;
    lb2_n_d = 1'b1;
    drv1_d  = 1'b0;
    drv2_d  = 1'b0;
    case (state_d)
      S_RD: begin
        // Reads always fetch both bytes.
        busy_d  = 1'b1;
        ram_a_d = addr_d;
        oe_n_d  = 1'b0;
        if (bank_d) begin
          ce2_n_d = 1'b0;
          ub2_n_d = 1'b0;
          lb2_n_d = 1'b0;
        end else begin
          ce1_n_d = 1'b0;
          ub1_n_d = 1'b0;
          lb1_n_d = 1'b0;
        end
      end
      S_WSETUP, S_WSTROBE, S_WHOLD: begin
        // Address, selects and data are held across setup and hold around we_n.
        busy_d  = 1'b1;
        ram_a_d = addr_d;
        we_n_d  = (state_d == S_WSTROBE) ? 1'b0 : 1'b1;
        if (bank_d) begin
          ce2_n_d = 1'b0;
          ub2_n_d = ~be_d[1];
          lb2_n_d = ~be_d[0];
          drv2_d  = 1'b1;
        end else begin
          ce1_n_d = 1'b0;
          ub1_n_d = ~be_d[1];
          lb1_n_d = ~be_d[0];
          drv1_d  = 1'b1;
        end
      end
      S_DONE: begin
        ack_d = 1'b1;
      end
      S_IDLE: begin
        ack_d = 1'b0;
      end
      default: begin
        ack_d = 1'b0;
      end
    endcase
  end

  // State, operation latch and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= 18'd0;
      wdata_q <= 16'd0;
      be_q    <= 2'b00;
      rdata_q <= 16'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ram_a_q <= 18'd0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ce1_n_q <= 1'b1;
      ub1_n_q <= 1'b1;
      lb1_n_q <= 1'b1;
      ce2_n_q <= 1'b1;
      ub2_n_q <= 1'b1;
      lb2_n_q <= 1'b1;
      drv1_q  <= 1'b0;
      drv2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ram_a_q <= ram_a_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ce1_n_q <= ce1_n_d;
      ub1_n_q <= ub1_n_d;
      lb1_n_q <= lb1_n_d;
      ce2_n_q <= ce2_n_d;
      ub2_n_q <= ub2_n_d;
      lb2_n_q <= lb2_n_d;
      drv1_q  <= drv1_d;
      drv2_q  <= drv2_d;
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign ram_a     = ram_a_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram1_ce_n = ce1_n_q;
  assign ram1_ub_n = ub1_n_q;
  assign ram1_lb_n = lb1_n_q;
  assign ram2_ce_n = ce2_n_q;
  assign ram2_ub_n = ub2_n_q;
  assign ram2_lb_n = lb2_n_q;

  // Data pins are driven only through the write phases of the selected chip.
  assign ram1_io = drv1_q ? wdata_q : 16'bz;
  assign ram2_io = drv2_q ? wdata_q : 16'bz;

endmodule

// File: tb/tb_sram_ctl_s3board.sv
// Scoreboard bench for sram_ctl_s3board with a behavioural model of two SRAMs.
module tb_sram_ctl_s3board;

  localparam int RC = 2;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset, req, we, bank;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic [15:0] rdata;
  logic        ack, busy;
  logic [17:0] ram_a;
  logic        ram_oe_n, ram_we_n;
  logic        ram1_ce_n, ram1_ub_n, ram1_lb_n;
  logic        ram2_ce_n, ram2_ub_n, ram2_lb_n;
  wire  [15:0] ram1_io, ram2_io;

  sram_ctl_s3board #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .bank(bank), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata), .ack(ack), .busy(busy),
    .ram_a(ram_a), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram1_io(ram1_io), .ram1_ce_n(ram1_ce_n), .ram1_ub_n(ram1_ub_n), .ram1_lb_n(ram1_lb_n),
    .ram2_io(ram2_io), .ram2_ce_n(ram2_ce_n), .ram2_ub_n(ram2_ub_n), .ram2_lb_n(ram2_lb_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: drives data while selected with oe_n low, writes while we_n low.
  logic [15:0] mem1 [0:262143];
  logic [15:0] mem2 [0:262143];
  int          w2_cnt = 0;

  assign ram1_io = (!ram1_ce_n && !ram_oe_n && ram_we_n) ? mem1[ram_a] : 16'bz;
  assign ram2_io = (!ram2_ce_n && !ram_oe_n && ram_we_n) ? mem2[ram_a] : 16'bz;

  always @(negedge clk) begin
    if (!ram1_ce_n && !ram_we_n) begin
      if (!ram1_ub_n) mem1[ram_a][15:8] <= ram1_io[15:8];
      if (!ram1_lb_n) mem1[ram_a][7:0]  <= ram1_io[7:0];
    end
    if (!ram2_ce_n && !ram_we_n) begin
      w2_cnt <= w2_cnt + 1;
      if (!ram2_ub_n) mem2[ram_a][15:8] <= ram2_io[15:8];
      if (!ram2_lb_n) mem2[ram_a][7:0]  <= ram2_io[7:0];
    end
  end

  typedef struct {
    logic        is_rd;
    logic [15:0] rd;
    int          ack_cyc;
    int          nwe;
    int          noe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe invariants every cycle, scoreboard pop on every ack.
  int          nwe = 0, noe = 0;
  logic        prev_we_n = 1'b1;
  logic [17:0] prev_a = 18'd0;
  logic [1:0]  prev_ce = 2'b11;
  always @(negedge clk) begin
    if (reset) begin
      nwe = 0;
      noe = 0;
    end else begin
      if (!ram_we_n) nwe++;
      if (!ram_oe_n) noe++;
      check("oe_we_exclusive", {31'd0, ram_oe_n | ram_we_n}, 32'd1);
      check("one_chip_selected", {31'd0, ram1_ce_n | ram2_ce_n}, 32'd1);
      if (!ram_we_n && !prev_we_n) begin
        check("addr_stable_we", {14'd0, ram_a}, {14'd0, prev_a});
        check("ce_stable_we", {30'd0, ram1_ce_n, ram2_ce_n}, {30'd0, prev_ce});
      end
      if (ack) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_cycle", cyc, mon_e.ack_cyc);
          check("we_low_cycles", nwe, mon_e.nwe);
          check("oe_low_cycles", noe, mon_e.noe);
          if (mon_e.is_rd) check("rdata", {16'd0, rdata}, {16'd0, mon_e.rd});
        end
        nwe = 0;
        noe = 0;
      end
    end
    prev_we_n = ram_we_n;
    prev_a    = ram_a;
    prev_ce   = {ram1_ce_n, ram2_ce_n};
  end

  // Issue one request at the first negedge with busy low; push its expectation.
  task automatic do_req(input logic w, input logic b, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] bytes, input logic [15:0] exp_rd);
    exp_t e;
    int   guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("busy_wait_timeout", {31'd0, busy}, 32'd0);
    req   = 1'b1;
    we    = w;
    bank  = b;
    addr  = a;
    wdata = d;
    be    = bytes;
    e.is_rd   = !w;
    e.rd      = exp_rd;
    e.ack_cyc = cyc + 1 + (w ? WC + 2 : RC);
    e.nwe     = w ? WC : 0;
    e.noe     = w ? 0 : RC;
    exp_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int guard;
    reset = 1'b1; req = 1'b0; we = 1'b0; bank = 1'b0;
    addr = 18'd0; wdata = 16'd0; be = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_strobes", {26'd0, ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n},
          {26'd0, 6'h3F});
    check("rst_bytes2", {30'd0, ram2_ub_n, ram2_lb_n}, {30'd0, 2'b11});
    check("rst_ack_busy", {30'd0, ack, busy}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_addr", {14'd0, ram_a}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: full write to ram1, ram2 untouched.
    do_req(1'b1, 1'b0, 18'o100, 16'h1234, 2'b11, 16'h0000);
    wait_done();
    check("t1_mem1", {16'd0, mem1[64]}, {16'd0, 16'h1234});
    check("t1_ram2_untouched", w2_cnt, 32'd0);

    // 2: read it back.
    do_req(1'b0, 1'b0, 18'o100, 16'h0000, 2'b11, 16'h1234);
    wait_done();

    // 3: low-byte write, then read merged word (back-to-back).
    do_req(1'b1, 1'b0, 18'o100, 16'hABCD, 2'b01, 16'h0000);
    do_req(1'b0, 1'b0, 18'o100, 16'h0000, 2'b11, 16'h12CD);
    wait_done();

    // 4: bank isolation.
    do_req(1'b1, 1'b1, 18'o100, 16'h5555, 2'b11, 16'h0000);
    do_req(1'b0, 1'b0, 18'o100, 16'h0000, 2'b11, 16'h12CD);
    do_req(1'b0, 1'b1, 18'o100, 16'h0000, 2'b11, 16'h5555);
    wait_done();

    // 5: request while busy is ignored; next request accepted in DONE.
    do_req(1'b0, 1'b0, 18'o100, 16'h0000, 2'b11, 16'h12CD);
    req = 1'b1; we = 1'b1; bank = 1'b0; addr = 18'o100; wdata = 16'hFFFF; be = 2'b11;
    @(negedge clk);
    req = 1'b0;
    do_req(1'b0, 1'b0, 18'o100, 16'h0000, 2'b11, 16'h12CD);
    wait_done();
    check("t5_mem1_unchanged", {16'd0, mem1[64]}, {16'd0, 16'h12CD});

    // 6: reset during the write strobe aborts without ack.
    req = 1'b1; we = 1'b1; bank = 1'b0; addr = 18'o200; wdata = 16'h7777; be = 2'b11;
    @(negedge clk);
    req = 1'b0;
    guard = 0;
    while (ram_we_n && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("t6_reached_strobe", {31'd0, ram_we_n}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_strobes", {26'd0, ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n},
          {26'd0, 6'h3F});
    check("t6_ack_busy", {30'd0, ack, busy}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_idle", {31'd0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
